// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: drives the sync RAM data port for loads/stores, aligns and
// extends load data after the one-cycle read latency, and holds a registered result for writeback.
module rv32i_mem_stage #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [1:0]        ex_width,
  input  logic              ex_sign,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_rd_we,
  output logic [ADDR_W-1:0] d_addr,
  output logic              d_we,
  output logic [3:0]        d_be,
  output logic [31:0]       d_wdata,
  input  logic [31:0]       d_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic              wb_rd_we,
  output logic [31:0]       wb_data,
  output logic              wb_misaligned,
  output logic [31:0]       wb_bad_addr
);
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q, width_q;
  logic              sign_q;
  logic [4:0]        rd_q;
  logic              rd_we_q, mis_q;
  logic [31:0]       data_q, bad_q;

  logic        accept, mis;
  logic [3:0]  be_raw;
  logic [31:0] sh, ld_val;

  always_comb begin
    mis = 1'b0;
    if (ex_load || ex_store) begin
      case (ex_width)
        2'b00:   mis = 1'b0;
        2'b01:   mis = ex_addr[0];
        2'b10:   mis = (ex_addr[1:0] != 2'b00);
        default: mis = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (ex_width)
      2'b00:   be_raw = 4'b0001 << ex_addr[1:0];
      2'b01:   be_raw = 4'b0011 << ex_addr[1:0];
      default: be_raw = 4'b1111;
    endcase
  end

  // Stalled while a load is in flight; in HOLD a new op may replace the consumed result.
  assign ex_ready = !reset && (state_q == IDLE || (state_q == HOLD && wb_ready));
  assign accept   = ex_valid && ex_ready;
  assign d_we     = accept && ex_store && !mis;
  assign d_be     = d_we ? be_raw : 4'b0000;
  assign d_wdata  = ex_wdata << {ex_addr[1:0], 3'b000};
  assign d_addr   = accept ? ex_addr[ADDR_W+1:2] : addr_q;

  assign sh = d_rdata >> {off_q, 3'b000};
  always_comb begin
    case (width_q)
      2'b00:   ld_val = {{24{sign_q & sh[7]}}, sh[7:0]};
      2'b01:   ld_val = {{16{sign_q & sh[15]}}, sh[15:0]};
      default: ld_val = sh;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= 2'b00;
      width_q <= 2'b00;
      sign_q  <= 1'b0;
      rd_q    <= 5'd0;
      rd_we_q <= 1'b0;
      mis_q   <= 1'b0;
      data_q  <= 32'd0;
      bad_q   <= 32'd0;
    end else begin
      case (state_q)
        READ: begin
          data_q  <= ld_val;
          state_q <= HOLD;
        end
        HOLD:    if (wb_ready && !ex_valid) state_q <= IDLE;
        default: ;
      endcase
      if (accept) begin
        addr_q  <= ex_addr[ADDR_W+1:2];
        off_q   <= ex_addr[1:0];
        width_q <= ex_width;
        sign_q  <= ex_sign;
        rd_q    <= ex_rd;
        mis_q   <= mis;
        bad_q   <= mis ? ex_addr : 32'd0;
        if (mis) begin
          rd_we_q <= 1'b0;
          data_q  <= 32'd0;
          state_q <= HOLD;
        end else if (ex_load) begin
          rd_we_q <= ex_rd_we;
          state_q <= READ;
        end else if (ex_store) begin
          rd_we_q <= 1'b0;
          data_q  <= 32'd0;
          state_q <= HOLD;
        end else begin
          rd_we_q <= ex_rd_we;
          data_q  <= ex_addr;
          state_q <= HOLD;
        end
      end
    end
  end

  assign wb_valid      = (state_q == HOLD);
  assign wb_rd         = rd_q;
  assign wb_rd_we      = rd_we_q;
  assign wb_data       = data_q;
  assign wb_misaligned = mis_q;
  assign wb_bad_addr   = bad_q;
endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Bench for rv32i_mem_stage: byte-level memory model plus a transaction-timing model
// checked every cycle, directed test-plan cases with literal expectations, then random traffic.
module tb_rv32i_mem_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready, ex_load = 1'b0, ex_store = 1'b0, ex_sign = 1'b0, ex_rd_we = 1'b0;
  logic [1:0]  ex_width = 2'b00;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic [29:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata, d_rdata;
  logic        wb_valid, wb_ready = 1'b1, wb_rd_we, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_bad_addr;

  int n_cmp = 0, n_err = 0;

  rv32i_mem_stage #(.ADDR_W(30)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load),
    .ex_store(ex_store), .ex_width(ex_width), .ex_sign(ex_sign), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .d_addr(d_addr), .d_we(d_we),
    .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_data(wb_data), .wb_misaligned(wb_misaligned),
    .wb_bad_addr(wb_bad_addr)
  );

  always #5 clk = ~clk;

  // Synchronous RAM stand-in: byte-enabled write, registered read.
  logic [31:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = 32'd0;
  always @(posedge clk) begin
    if (d_we)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) ram[d_addr[5:0]][8*b +: 8] <= d_wdata[8*b +: 8];
    d_rdata <= ram[d_addr[5:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte memory, one result slot, and a pending-load flag.
  logic [7:0]  mmem [256];
  logic        m_valid = 1'b0, m_pend = 1'b0, m_chk_data = 1'b0;
  logic [29:0] m_last = 30'd0;
  logic [4:0]  m_rd;
  logic        m_rd_we, m_mis;
  logic [31:0] m_data, m_bad;
  logic        e_rdy, e_acc, e_mis, e_we;
  int          sz;
  logic [31:0] v;
  initial for (int i = 0; i < 256; i++) mmem[i] = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      m_valid = 1'b0; m_pend = 1'b0; m_last = 30'd0;
      chk("rst ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      chk("rst wb_bad_addr", wb_bad_addr, 32'd0);
      chk("rst wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst wb_flags", {30'd0, wb_rd_we, wb_misaligned}, 32'd0);
      chk("rst d_port", {d_addr, d_we, d_be}, 35'd0);
    end else begin
      e_rdy = !m_pend && (!m_valid || wb_ready);
      chk("ex_ready", {31'd0, ex_ready}, {31'd0, e_rdy});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
        chk("wb_rd_we", {31'd0, wb_rd_we}, {31'd0, m_rd_we});
        chk("wb_misaligned", {31'd0, wb_misaligned}, {31'd0, m_mis});
        chk("wb_bad_addr", wb_bad_addr, m_bad);
        if (m_chk_data) chk("wb_data", wb_data, m_data);
      end
      e_acc = ex_valid && e_rdy;
      sz    = 1 << ex_width;
      e_mis = (ex_load || ex_store) &&
              (ex_width == 2'b11 || (ex_addr % sz) != 0);
      e_we  = e_acc && ex_store && !e_mis;
      chk("d_we", {31'd0, d_we}, {31'd0, e_we});
      chk("d_addr", {2'd0, d_addr}, e_acc ? {2'd0, ex_addr[31:2]} : {2'd0, m_last});
      if (e_we) begin
        chk("d_be", {28'd0, d_be}, ((32'd1 << sz) - 32'd1) << ex_addr[1:0]);
        chk("d_wdata", d_wdata, ex_wdata << (8 * ex_addr[1:0]));
      end
      if (m_valid && wb_ready) m_valid = 1'b0;
      if (m_pend) begin m_pend = 1'b0; m_valid = 1'b1; end
      if (e_acc) begin
        m_last = ex_addr[31:2];
        m_rd = ex_rd; m_mis = e_mis; m_bad = e_mis ? ex_addr : 32'd0;
        m_rd_we = (ex_store || e_mis) ? 1'b0 : ex_rd_we;
        m_chk_data = !ex_store || e_mis;
        if (e_mis) m_data = 32'd0;
        else if (ex_store) begin
          for (int i = 0; i < sz; i++) mmem[8'(ex_addr[7:0] + i)] = ex_wdata[8*i +: 8];
        end else if (ex_load) begin
          v = 32'd0;
          for (int i = 0; i < sz; i++) v = v | (32'(mmem[8'(ex_addr[7:0] + i)]) << (8 * i));
          if (ex_sign && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
          m_data = v;
        end else m_data = ex_addr;
        if (ex_load && !e_mis) m_pend = 1'b1;
        else m_valid = 1'b1;
      end
    end
  end

  // Presents one op (caller is just past a rising edge) and returns just past its accept edge.
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [29:0] cap_addr;
  logic [31:0] cap_wd;
  task automatic issue(input logic ld, input logic st, input logic [1:0] w, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rdwe);
    bit acc = 0;
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_width = w; ex_sign = sg;
    ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_rd_we = rdwe;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (ex_ready) begin
        acc = 1; cap_we = d_we; cap_be = d_be; cap_addr = d_addr; cap_wd = d_wdata;
      end
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL issue timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();

    // Byte stores
    issue(0, 1, 2'b00, 0, 32'h50, 32'h80, 5'd1, 1);
    chk("sb0 d_addr", {2'd0, cap_addr}, 32'h14);
    chk("sb0 d_be", {28'd0, cap_be}, 32'h1);
    chk("sb0 d_wdata", {24'd0, cap_wd[7:0]}, 32'h80);
    @(negedge clk);
    chk("sb0 wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sb0 wb_rd_we", {31'd0, wb_rd_we}, 32'd0);
    step();
    issue(0, 1, 2'b00, 0, 32'h53, 32'h50, 5'd1, 1);
    chk("sb3 d_be", {28'd0, cap_be}, 32'h8);
    chk("sb3 d_wdata", cap_wd, 32'h5000_0000);
    @(negedge clk);
    chk("sb3 wb_valid", {31'd0, wb_valid}, 32'd1);
    step();

    // Word store, then back-to-back unsigned half load from the upper half
    issue(0, 1, 2'b10, 0, 32'h60, 32'h1234_5678, 5'd0, 0);
    issue(1, 0, 2'b01, 0, 32'h62, 32'd0, 5'd5, 1);
    @(negedge clk);
    chk("lhu lat1 wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("lhu wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lhu wb_data", wb_data, 32'h0000_1234);
    step();

    // Half extension
    issue(0, 1, 2'b01, 0, 32'h60, 32'h0000_FFFB, 5'd0, 0);
    issue(1, 0, 2'b01, 1, 32'h60, 32'd0, 5'd6, 1);
    repeat (2) @(negedge clk);
    chk("lh signed", wb_data, 32'hFFFF_FFFB);
    step();
    issue(1, 0, 2'b01, 0, 32'h60, 32'd0, 5'd6, 1);
    repeat (2) @(negedge clk);
    chk("lh unsigned", wb_data, 32'h0000_FFFB);
    step();

    // Misaligned word store
    issue(0, 1, 2'b10, 0, 32'h61, 32'hDEAD_BEEF, 5'd2, 1);
    chk("sw mis d_we", {31'd0, cap_we}, 32'd0);
    @(negedge clk);
    chk("sw mis flag", {31'd0, wb_misaligned}, 32'd1);
    chk("sw mis bad_addr", wb_bad_addr, 32'h61);
    chk("sw mis rd_we", {31'd0, wb_rd_we}, 32'd0);
    step(); step();

    // Backpressure on a pending load result
    wb_ready = 1'b0;
    issue(1, 0, 2'b10, 0, 32'h60, 32'd0, 5'd7, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp ex_ready", {31'd0, ex_ready}, 32'd0);
      chk("bp wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("bp wb_data", wb_data, 32'h1234_FFFB);
    end
    step();
    wb_ready = 1'b1;
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_addr = 32'h7; ex_rd = 5'd3; ex_rd_we = 1'b1;
    @(negedge clk);
    chk("bp alu ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("bp alu wb_data", wb_data, 32'h7);
    step(); step();

    // Reset during READ
    issue(1, 0, 2'b10, 0, 32'h50, 32'd0, 5'd4, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstrd wb_valid", {31'd0, wb_valid}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rstrd ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rstrd wb_valid", {31'd0, wb_valid}, 32'd0);
    step();

    // Random traffic under random backpressure
    for (int c = 0; c < 3000; c++) begin
      int kind;
      kind     = $urandom_range(0, 2);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_load  = (kind == 1);
      ex_store = (kind == 2);
      ex_width = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ex_sign  = 1'($urandom);
      ex_addr  = (kind == 0) ? $urandom : 32'($urandom_range(0, 255));
      ex_wdata = $urandom;
      ex_rd    = 5'($urandom);
      ex_rd_we = 1'($urandom);
      wb_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    ex_valid = 1'b0; wb_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
